log_multiply_arbiter: RTL and testbench

Shares one pipelined log-domain multiplier among `NUM_REQ` requesters. Each requester presents a pair of packed log numbers (`M` integer, `F` fraction bits) with a valid/ready handshake. A round-robin arbiter admits at most one pair per cycle into a `PIPE`-stage pipeline around the unpacked log multiply. The product is re-encoded to a packed log number and returned on a single tagged response port with backpressure. The block sits between PE-level operand queues and the shared multiplier in the log-arithmetic accumulator path.

---
 rtl/log_multiply_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_log_multiply_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/log_multiply_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : log_multiply_arbiter
// Brief    : Round-robin arbiter sharing one pipelined packed-log multiplier.
//            Optional statistics counters: LOG_MULTIPLY_ARB_STATS_EN.
// Revision : 1.0
// ============================================================================
// Packed number: {sign, LW-bit two's-complement log2 magnitude in M.F}.
// Log field most-negative = zero, most-positive = inf/saturated max.
module log_multiply_arbiter #(
    parameter int M       = 3,
    parameter int F       = 4,
    parameter int NUM_REQ = 4,
    parameter int PIPE    = 2,
    localparam int W      = 1 + M + F,
    localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*W-1:0] req_a,
    input  logic [NUM_REQ*W-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 resp_valid,
    output logic [IDW-1:0]       resp_id,
    output logic [W-1:0]         resp_c,
    input  logic                 resp_ready
`ifdef LOG_MULTIPLY_ARB_STATS_EN
    ,
    output logic [31:0]          busy_cycles,
    output logic [31:0]          stall_cycles
`endif
);

    localparam int LW = M + F;
    localparam int UW = LW + 4;
    localparam logic [LW-1:0]        c_zero_code = {1'b1, {(LW-1){1'b0}}};
    localparam logic [LW-1:0]        c_inf_code  = {1'b0, {(LW-1){1'b1}}};
    localparam logic signed [LW:0]   c_max_s     = {2'b00, {(LW-1){1'b1}}};
    localparam logic signed [LW:0]   c_min_s     = {2'b11, {(LW-1){1'b0}}};

    // Unpacked product: {sign, zero, inf, LW+1-bit log sum}
    function automatic logic [UW-1:0] f_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic za, zb, ia, ib;
        logic signed [LW:0] s;
        za = (a[LW-1:0] == c_zero_code);
        zb = (b[LW-1:0] == c_zero_code);
        ia = (a[LW-1:0] == c_inf_code);
        ib = (b[LW-1:0] == c_inf_code);
        s  = signed'({a[LW-1], a[LW-1:0]}) + signed'({b[LW-1], b[LW-1:0]});
        return {a[W-1] ^ b[W-1], (za | zb) & ~(ia | ib), ia | ib, s};
    endfunction

    function automatic logic [W-1:0] f_pack(input logic [UW-1:0] u);
        logic sgn;
        logic signed [LW:0] s;
        sgn = u[UW-1];
        s   = signed'(u[LW:0]);
        if (u[UW-3])         return {sgn, c_inf_code};
        else if (u[UW-2])    return {1'b0, c_zero_code};
        else if (s >= c_max_s) return {sgn, c_inf_code};
        else if (s <= c_min_s) return {1'b0, c_zero_code};
        else                 return {sgn, s[LW-1:0]};
    endfunction

    logic [PIPE-1:0]  r_vld;
    logic [IDW-1:0]   r_id [PIPE];
    logic [W-1:0]     r_c;
    logic [IDW-1:0]   r_rr;

    logic             w_advance;
    logic             w_found;
    logic             w_xfer;
    logic [IDW-1:0]   w_gnt_id;
    logic [IDW:0]     w_sum;
    logic [IDW-1:0]   w_cand;
    logic [NUM_REQ-1:0] w_grant;
    logic [W-1:0]     w_a;
    logic [W-1:0]     w_b;
    logic [UW-1:0]    w_prod;

    assign w_advance = !(r_vld[PIPE-1] && !resp_ready);

    // First valid requester at or after the pointer, wrapping modulo NUM_REQ
    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = '0;
        w_sum    = '0;
        w_cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_rr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDW+1)'(NUM_REQ);
            end
            w_cand = w_sum[IDW-1:0];
            if (!w_found && req_valid[w_cand]) begin
                w_found  = 1'b1;
                w_gnt_id = w_cand;
            end
        end
    end

    assign w_xfer = w_found && w_advance && !reset;

    always_comb begin
        w_grant = '0;
        if (w_xfer) begin
            w_grant[w_gnt_id] = 1'b1;
        end
    end

    assign req_ready = w_grant;
    assign w_a       = req_a[int'(w_gnt_id)*W +: W];
    assign w_b       = req_b[int'(w_gnt_id)*W +: W];
    assign w_prod    = f_mul(w_a, w_b);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_vld <= '0;
            r_rr  <= '0;
            for (int k = 0; k < PIPE; k++) begin
                r_id[k] <= '0;
            end
        end else if (w_advance) begin
            r_vld[0] <= w_xfer;
            r_id[0]  <= w_gnt_id;
            for (int k = 1; k < PIPE; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_id[k]  <= r_id[k-1];
            end
            if (w_xfer) begin
                r_rr <= (w_gnt_id == IDW'(NUM_REQ-1)) ? '0 : w_gnt_id + 1'b1;
            end
        end
    end

    generate
        if (PIPE == 1) begin : g_pipe_one
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_c <= '0;
                end else if (w_advance) begin
                    r_c <= f_pack(w_prod);
                end
            end
        end else begin : g_pipe_multi
            logic [UW-1:0] r_u [PIPE-1];
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_c <= '0;
                    for (int k = 0; k < PIPE-1; k++) begin
                        r_u[k] <= '0;
                    end
                end else if (w_advance) begin
                    r_u[0] <= w_prod;
                    for (int k = 1; k < PIPE-1; k++) begin
                        r_u[k] <= r_u[k-1];
                    end
                    r_c <= f_pack(r_u[PIPE-2]);
                end
            end
        end
    endgenerate

    assign resp_valid = r_vld[PIPE-1];
    assign resp_id    = r_id[PIPE-1];
    assign resp_c     = r_c;

`ifdef LOG_MULTIPLY_ARB_STATS_EN
    logic [31:0] r_busy;
    logic [31:0] r_stall;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_busy  <= '0;
            r_stall <= '0;
        end else begin
            if (|r_vld)     r_busy  <= r_busy + 32'd1;
            if (!w_advance) r_stall <= r_stall + 32'd1;
        end
    end
    assign busy_cycles  = r_busy;
    assign stall_cycles = r_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_log_multiply_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_log_multiply_arbiter
// Brief    : Scoreboard bench for log_multiply_arbiter (real-valued reference).
// Revision : 1.0
// ============================================================================
module tb_log_multiply_arbiter;
    localparam int M = 3, F = 4, N = 4, PIPE = 2;
    localparam int W = 1 + M + F, IDW = 2, LW = M + F;
    localparam int MAXC = 2**(LW-1) - 1;
    localparam int MINC = -(2**(LW-1));

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0]   req_ready;
    logic           resp_valid;
    logic [IDW-1:0] resp_id;
    logic [W-1:0]   resp_c;
    logic           resp_ready = 1'b1;
`ifdef LOG_MULTIPLY_ARB_STATS_EN
    logic [31:0]    busy_cycles;
    logic [31:0]    stall_cycles;
`endif

    log_multiply_arbiter #(.M(M), .F(F), .NUM_REQ(N), .PIPE(PIPE)) u_dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_a(req_a),
        .req_b(req_b), .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_id(resp_id), .resp_c(resp_c), .resp_ready(resp_ready)
`ifdef LOG_MULTIPLY_ARB_STATS_EN
        , .busy_cycles(busy_cycles), .stall_cycles(stall_cycles)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [W-1:0]   c;
    } exp_t;

    exp_t         sbq[$];
    int           n_vec = 0;
    int           n_err = 0;
    logic [N-1:0] r_xfer = '0;
    int           n_in = 0;
    logic [31:0]  exp_busy = '0;
    logic [31:0]  exp_stall = '0;
    int           mode = 0;
    int           sweep_p = 0;
    logic [W-1:0] bset [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Reference: decode to reals, multiply, re-encode by rounding log2
    function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        int la, lb, li;
        real lp, scale;
        logic s;
        la = $signed(a[LW-1:0]);
        lb = $signed(b[LW-1:0]);
        s  = a[W-1] ^ b[W-1];
        scale = real'(2**F);
        if (la == MAXC || lb == MAXC) return {s, LW'(MAXC)};
        if (la == MINC || lb == MINC) return {1'b0, LW'(MINC)};
        lp = $ln((2.0 ** (la / scale)) * (2.0 ** (lb / scale))) / $ln(2.0) * scale;
        li = (lp >= 0.0) ? $rtoi(lp + 0.5) : -$rtoi(-lp + 0.5);
        if (li >= MAXC) return {s, LW'(MAXC)};
        if (li <= MINC) return {1'b0, LW'(MINC)};
        return {s, LW'(li)};
    endfunction

    function automatic logic [W-1:0] rand_op();
        logic [W-1:0] v;
        v = W'($urandom);
        if ($urandom_range(3) == 0) begin
            case ($urandom_range(5))
                0: v = 8'h40;
                1: v = 8'h3F;
                2: v = 8'h3E;
                3: v = 8'hC0;
                4: v = 8'hBF;
                default: v = 8'h41;
            endcase
        end
        return v;
    endfunction

    // Expectation producer: records every accepted pair
    always @(negedge clock) begin
        if (reset) begin
            sbq.delete();
            r_xfer    = '0;
            n_in      = 0;
            exp_busy  = '0;
            exp_stall = '0;
        end else begin
            check("req_ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
            r_xfer = req_valid & req_ready;
            for (int i = 0; i < N; i++) begin
                if (r_xfer[i]) sbq.push_back('{id: IDW'(i), c: ref_mul(req_a[i*W +: W], req_b[i*W +: W])});
            end
            if (n_in > 0) exp_busy++;
            if (resp_valid && !resp_ready) exp_stall++;
            n_in = n_in + $countones(r_xfer) - ((resp_valid && resp_ready) ? 1 : 0);
        end
    end

    // Response monitor
    always @(negedge clock) begin
        exp_t e;
        if (!reset && resp_valid && resp_ready) begin
            if (sbq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_resp: actual id %0d c %0h required no response", resp_id, resp_c);
            end else begin
                e = sbq.pop_front();
                check("resp_id", 32'(resp_id), 32'(e.id));
                check("resp_c", 32'(resp_c), 32'(e.c));
            end
        end
    end

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            if (mode == 1 && r_xfer[i]) begin
                set_req(i, rand_op(), rand_op());
            end else if (mode == 2 && (r_xfer[i] || !req_valid[i])) begin
                req_valid[i] = ($urandom_range(2) != 0);
                set_req(i, rand_op(), rand_op());
            end else if (mode == 3 && (r_xfer[i] || !req_valid[i])) begin
                if (sweep_p < 4096) begin
                    req_valid[i] = 1'b1;
                    set_req(i, W'(sweep_p), bset[sweep_p >> 8]);
                    sweep_p++;
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        refresh();
    endtask

    task automatic chk_reset_outputs(input string tag);
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_resp_id"}, 32'(resp_id), 32'd0);
        check({tag, "_resp_c"}, 32'(resp_c), 32'd0);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    endtask

    task automatic send_one(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] req_c, input string name);
        bit found;
        mode = 0;
        @(posedge clock);
        #1;
        set_req(i, a, b);
        req_valid[i] = 1'b1;
        found = 0;
        for (int t = 0; t < 20 && !found; t++) begin
            @(negedge clock);
            if (req_ready[i]) found = 1;
        end
        check({name, "_grant"}, 32'(found), 32'd1);
        for (int k = 1; k <= PIPE; k++) begin
            @(posedge clock);
            #1;
            if (k == 1) req_valid[i] = 1'b0;
            @(negedge clock);
            check({name, "_latency"}, 32'(resp_valid), 32'(k == PIPE));
        end
        check({name, "_id"}, 32'(resp_id), 32'(i));
        check({name, "_c"}, 32'(resp_c), 32'(req_c));
    endtask

    task automatic chk_stats(input string tag);
`ifdef LOG_MULTIPLY_ARB_STATS_EN
        check({tag, "_busy_cycles"}, busy_cycles, exp_busy);
        check({tag, "_stall_cycles"}, stall_cycles, exp_stall);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1);
    end

    initial begin
        bset = '{8'h00, 8'h10, 8'h70, 8'h40, 8'h3F, 8'h3E, 8'hC1, 8'hBF,
                 8'h80, 8'h41, 8'h20, 8'h9F, 8'h01, 8'h7F, 8'hE8, 8'h1F};

        // Reset state with all requesters asking
        req_valid = '1;
        repeat (3) @(negedge clock);
        chk_reset_outputs("reset");
        chk_stats("reset");
        @(posedge clock);
        #1;
        reset = 1'b0;
        req_valid = '0;

        // 2.0 * 0.5 = 1.0 with latency check; then special values
        send_one(0, 8'h10, 8'h70, 8'h00, "two_x_half");
        send_one(1, 8'h40, 8'h20, 8'h40, "zero_x_four");
        send_one(2, 8'h3F, 8'h40, 8'h3F, "inf_x_zero");
        send_one(3, 8'h3E, 8'h3E, 8'h3F, "max_x_max");
        send_one(0, 8'h90, 8'h10, 8'hA0, "neg_two_x_two");

        // Round-robin from a fresh pointer, all valid, no backpressure
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        mode = 1;
        for (int i = 0; i < N; i++) set_req(i, rand_op(), rand_op());
        req_valid = '1;
        resp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            @(negedge clock);
            check("rr_grant", 32'(req_ready), 32'(1 << (k % N)));
            check("rr_no_bubble", 32'(resp_valid), 32'(k >= PIPE));
        end

        // Five-cycle stall with a full pipeline
        tick();
        resp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick();
            @(negedge clock);
            check("stall_req_ready", 32'(req_ready), 32'd0);
            check("stall_resp_valid", 32'(resp_valid), 32'd1);
            if (sbq.size() > 0) begin
                check("stall_resp_id", 32'(resp_id), 32'(sbq[0].id));
                check("stall_resp_c", 32'(resp_c), 32'(sbq[0].c));
            end
        end
        tick();
        resp_ready = 1'b1;
        tick();
        chk_stats("after_stall");
        repeat (4) tick();

        // Asynchronous reset in the middle of a burst
        @(posedge clock);
        #1;
        refresh();
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outputs("async_reset");
        @(posedge clock);
        #1;
        refresh();
        #2;
        reset = 1'b0;
        @(negedge clock);
        check("post_reset_grant", 32'(req_ready), 32'd1);
        repeat (10) tick();

        // Randomized traffic with random backpressure
        mode = 2;
        for (int c = 0; c < 3000; c++) begin
            tick();
            resp_ready = ($urandom_range(3) != 0);
        end

        // Sweep every A against a fixed B set
        mode = 3;
        req_valid = '0;
        for (int c = 0; c < 10000 && sweep_p < 4096; c++) begin
            tick();
            resp_ready = ($urandom_range(7) != 0);
        end
        check("sweep_done", 32'(sweep_p), 32'd4096);

        // Drain
        mode = 0;
        req_valid = '0;
        resp_ready = 1'b1;
        for (int c = 0; c < 20 && sbq.size() > 0; c++) tick();
        tick();
        check("drain_empty", 32'(sbq.size()), 32'd0);
        chk_stats("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
